// File: rtl/fetch_unit.sv
// fetch_unit: credit-based instruction fetcher feeding a downstream ring buffer.
// Optional FETCH_STALL_CNT_EN adds a saturating credit-stall counter on o_stall_cnt.
module fetch_unit #(
    parameter int XLEN = 32,
    parameter int DEPTH = 8,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_redirect,
    input  logic [XLEN-1:0]              i_redirect_pc,
    output logic                         o_imem_req,
    output logic [XLEN-1:0]              o_imem_addr,
    input  logic                         i_imem_gnt,
    input  logic                         i_imem_rvalid,
    input  logic [31:0]                  i_imem_rdata,
    output logic                         o_we,
    output logic [XLEN+31:0]             o_data,
    input  logic                         i_re,
    output logic [$clog2(DEPTH+1)-1:0]   o_credits,
    output logic [15:0]                  o_stall_cnt
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DROP} state_t;

    state_t state, state_nx;
    logic [XLEN-1:0] pc;
    logic [CW-1:0] credits, cred_nx;
    logic [CW:0] cred_sum;
    logic accept, resp, push, ret;

    assign accept = state == REQ && i_imem_gnt;
    assign resp = (state == RESP || state == DROP) && i_imem_rvalid;
    assign push = state == RESP && i_imem_rvalid && !i_redirect;
    // any response that is not pushed gives its reserved slot back
    assign ret = resp && !push;
    assign cred_sum = {1'b0, credits} + (CW + 1)'(i_re) + (CW + 1)'(ret) - (CW + 1)'(accept);
    assign cred_nx = cred_sum > FULL ? CW'(DEPTH) : cred_sum[CW-1:0];

    assign o_imem_req = state == REQ;
    assign o_imem_addr = pc;
    assign o_credits = credits;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = (credits != '0 && !i_redirect) ? REQ : IDLE;
            REQ:  state_nx = accept ? (i_redirect ? DROP : RESP) : (i_redirect ? IDLE : REQ);
            RESP: state_nx = i_imem_rvalid ? ((push && cred_nx != '0) ? REQ : IDLE)
                                           : (i_redirect ? DROP : RESP);
            DROP: state_nx = i_imem_rvalid ? IDLE : DROP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            pc <= RESET_PC;
            credits <= CW'(DEPTH);
            o_we <= 1'b0;
            o_data <= '0;
        end else begin
            state <= state_nx;
            credits <= cred_nx;
            o_we <= push;
            if (push)
                o_data <= {pc, i_imem_rdata};
            pc <= i_redirect ? (i_redirect_pc & ~XLEN'(3)) : push ? pc + XLEN'(4) : pc;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            stall_cnt <= '0;
        else if (state == IDLE && credits == '0 && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign o_stall_cnt = stall_cnt;
`else
    assign o_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plus randomized checks of fetch_unit against a transaction-level model.
module tb_fetch_unit;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1, redirect = 1'b0, gnt = 1'b0, rvalid = 1'b0, re = 1'b0;
    logic [31:0] rpc = '0, rdata = '0;
    logic imem_req, we;
    logic [31:0] imem_addr;
    logic [63:0] data;
    logic [3:0] credits;
    logic [15:0] stall_cnt;

    int total = 0, bad = 0;

    // transaction-level model: a fetch is wanted, in flight, or in flight but squashed
    bit m_armed, m_inflight, m_doomed, m_we;
    int m_cred, m_stall;
    logic [31:0] m_pc;
    logic [63:0] m_data;

    // memory responder and observation logs
    bit r_pend;
    int r_wait, dly = 1;
    bit req_now;
    logic [31:0] addr_now;
    logic [31:0] pushq[$], accq[$];

    fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .i_clk(clk), .i_rst(rst), .i_redirect(redirect), .i_redirect_pc(rpc),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(gnt),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata), .o_we(we), .o_data(data),
        .i_re(re), .o_credits(credits), .o_stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit acc, rsp, rt, psh;
        int nc;
        if (rst) begin
            m_armed = 0; m_inflight = 0; m_doomed = 0; m_we = 0;
            m_cred = DEPTH; m_stall = 0; m_pc = 32'h0; m_data = '0;
        end else begin
            acc = m_armed && gnt;
            rsp = m_inflight && rvalid;
            rt = rsp && (m_doomed || redirect);
            psh = rsp && !rt;
            nc = m_cred - int'(acc) + int'(re) + int'(rt);
            if (nc > DEPTH) nc = DEPTH;
            if (!m_armed && !m_inflight && m_cred == 0 && m_stall < 65535) m_stall++;
            m_we = psh;
            if (psh) m_data = {m_pc, rdata};
            if (acc) begin
                m_inflight = 1; m_doomed = redirect; m_armed = 0;
            end else if (rsp) begin
                m_inflight = 0; m_doomed = 0; m_armed = psh && nc > 0;
            end else if (m_armed && redirect) begin
                m_armed = 0;
            end else if (m_inflight && redirect) begin
                m_doomed = 1;
            end else if (!m_armed && !m_inflight) begin
                m_armed = m_cred > 0 && !redirect;
            end
            m_pc = redirect ? (rpc & ~32'h3) : psh ? m_pc + 32'd4 : m_pc;
            m_cred = nc;
        end
    endtask

    task automatic step();
        rvalid = r_pend && r_wait == 0;
        rdata = $urandom;
        req_now = imem_req;
        addr_now = imem_addr;
        @(posedge clk);
        model_update();
        if (rvalid) r_pend = 0;
        else if (r_pend && r_wait > 0) r_wait--;
        if (req_now && gnt && !rst) begin
            r_pend = 1; r_wait = dly - 1; accq.push_back(addr_now);
        end
        @(negedge clk);
        chk("imem_req", 64'(imem_req), 64'(m_armed));
        if (m_armed) chk("imem_addr", 64'(imem_addr), 64'(m_pc));
        chk("credits", 64'(credits), 64'(m_cred));
        chk("we", 64'(we), 64'(m_we));
        if (m_we) chk("data", data, m_data);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`else
        chk("stall_cnt", 64'(stall_cnt), 64'h0);
`endif
        if (we) pushq.push_back(data[63:32]);
    endtask

    task automatic pulse_re(int n);
        re = 1;
        repeat (n) step();
        re = 0;
    endtask

    initial begin
        logic [15:0] s0;
        repeat (2) step();
        chk("reset_credits", 64'(credits), 64'd8);
        chk("reset_req", 64'(imem_req), 64'd0);
        rst = 0;
        gnt = 1;
        // fill the buffer from reset
        repeat (40) step();
        chk("fill_pushes", 64'(pushq.size()), 64'd8);
        chk("fill_first_pc", 64'(pushq[0]), 64'h0);
        chk("fill_last_pc", 64'(pushq[7]), 64'h1C);
        chk("fill_credits", 64'(credits), 64'd0);
        chk("fill_req", 64'(imem_req), 64'd0);
        // single credit return refetches the next word
        pushq.delete(); accq.delete();
        pulse_re(1);
        chk("ret_credit", 64'(credits), 64'd1);
        repeat (10) step();
        chk("ret_accepts", 64'(accq.size()), 64'd1);
        chk("ret_addr", 64'(accq[0]), 64'h20);
        chk("ret_pushes", 64'(pushq.size()), 64'd1);
        chk("ret_credits0", 64'(credits), 64'd0);
        // redirect during RESP, response two cycles later is dropped
        pushq.delete(); accq.delete();
        dly = 3;
        pulse_re(1);
        repeat (2) step();
        redirect = 1; rpc = 32'h103;
        step();
        redirect = 0;
        chk("drop_req", 64'(imem_req), 64'd0);
        repeat (12) step();
        chk("drop_refetch", 64'(accq[1]), 64'h100);
        chk("drop_pushes", 64'(pushq.size()), 64'd1);
        chk("drop_push_pc", 64'(pushq[0]), 64'h100);
        // redirect coinciding with rvalid
        pushq.delete(); accq.delete();
        dly = 1;
        pulse_re(1);
        repeat (2) step();
        redirect = 1; rpc = 32'h200;
        step();
        redirect = 0;
        chk("coll_we", 64'(we), 64'd0);
        chk("coll_credits", 64'(credits), 64'd1);
        repeat (10) step();
        // PC wrap across two fetches
        gnt = 0;
        pulse_re(2);
        redirect = 1; rpc = 32'hFFFF_FFFC;
        step();
        redirect = 0;
        pushq.delete();
        gnt = 1;
        repeat (12) step();
        chk("wrap_pushes", 64'(pushq.size()), 64'd2);
        chk("wrap_pc0", 64'(pushq[0]), 64'hFFFF_FFFC);
        chk("wrap_pc1", 64'(pushq[1]), 64'h0);
        // full buffer idling
        s0 = stall_cnt;
        repeat (20) step();
`ifdef FETCH_STALL_CNT_EN
        chk("stall_20", 64'(stall_cnt - s0), 64'd20);
`else
        chk("stall_off", 64'(stall_cnt), 64'd0);
`endif
        // randomized traffic with resets, redirects and credit returns
        for (int i = 0; i < 4000; i++) begin
            rst = $urandom_range(0, 299) == 0;
            gnt = $urandom_range(0, 3) != 0;
            re = $urandom_range(0, 2) == 0;
            redirect = $urandom_range(0, 15) == 0;
            rpc = $urandom;
            dly = $urandom_range(1, 3);
            step();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
